// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Decode-to-execute operand/control bundle and execute-to-memory
//            results, with the combinational stall returned upstream.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_stage_if;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  AluOp;
    logic        AluSrc;
    logic        Branch;
    logic        Jump;
    logic        Jalr;
    logic [2:0]  BranchOp;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegWrite;
    logic [4:0]  RegDest;
    logic        flush;

    logic [31:0] out_AluResult;
    logic [31:0] out_StoreData;
    logic [31:0] out_BranchTarget;
    logic [4:0]  out_RegDest;
    logic        out_MemRead;
    logic        out_MemWrite;
    logic        out_MemToReg;
    logic        out_RegWrite;
    logic        out_PCSrc;
    logic        stall_pipeline;

    modport master (
        output pc, rs1_data, rs2_data, imm, AluOp, AluSrc, Branch, Jump, Jalr,
               BranchOp, MemRead, MemWrite, MemToReg, RegWrite, RegDest, flush,
        input  out_AluResult, out_StoreData, out_BranchTarget, out_RegDest,
               out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite, out_PCSrc,
               stall_pipeline
    );

    modport slave (
        input  pc, rs1_data, rs2_data, imm, AluOp, AluSrc, Branch, Jump, Jalr,
               BranchOp, MemRead, MemWrite, MemToReg, RegWrite, RegDest, flush,
        output out_AluResult, out_StoreData, out_BranchTarget, out_RegDest,
               out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite, out_PCSrc,
               stall_pipeline
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Pipeline EX stage - ALU, branch/jump resolution and, when the
//            macro M_EXT_EN is defined, multiply plus a 34-cycle divider.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage (
    input  wire logic      clk,
    input  wire logic      rst,
    execute_stage_if.slave bus
);
    localparam logic [4:0] c_OP_ADD    = 5'd0;
    localparam logic [4:0] c_OP_SUB    = 5'd1;
    localparam logic [4:0] c_OP_SLL    = 5'd2;
    localparam logic [4:0] c_OP_SLT    = 5'd3;
    localparam logic [4:0] c_OP_SLTU   = 5'd4;
    localparam logic [4:0] c_OP_XOR    = 5'd5;
    localparam logic [4:0] c_OP_SRL    = 5'd6;
    localparam logic [4:0] c_OP_SRA    = 5'd7;
    localparam logic [4:0] c_OP_OR     = 5'd8;
    localparam logic [4:0] c_OP_AND    = 5'd9;
    localparam logic [4:0] c_OP_PASSB  = 5'd10;
    localparam logic [4:0] c_OP_MUL    = 5'd11;
    localparam logic [4:0] c_OP_MULH   = 5'd12;
    localparam logic [4:0] c_OP_MULHSU = 5'd13;
    localparam logic [4:0] c_OP_MULHU  = 5'd14;
    localparam logic [4:0] c_OP_DIV    = 5'd15;
    localparam logic [4:0] c_OP_DIVU   = 5'd16;
    localparam logic [4:0] c_OP_REM    = 5'd17;
    localparam logic [4:0] c_OP_REMU   = 5'd18;

    logic [31:0] w_a, w_b, w_alu, w_result, w_target, w_jt;
    logic        w_take, w_pcsrc, w_stall, w_bubble;

    logic [31:0] res_q, store_q, tgt_q;
    logic [4:0]  rd_q;
    logic        mr_q, mw_q, m2r_q, rw_q, pcs_q;

    assign w_a      = bus.rs1_data;
    assign w_b      = bus.AluSrc ? bus.imm : bus.rs2_data;
    assign w_jt     = bus.rs1_data + bus.imm;
    assign w_target = (bus.Jump && bus.Jalr) ? (w_jt & 32'hFFFF_FFFE) : (bus.pc + bus.imm);

`ifdef M_EXT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        w_sgn, w_isrem, w_isdiv, w_div0, w_ovf, w_start, w_msgn_a, w_msgn_b;
    logic [63:0] w_xa, w_xb, w_prod;
    logic [31:0] w_mag_a, w_mag_b, w_fast, w_quot, w_remd, w_divres;
    logic [32:0] w_trial;

    assign w_sgn   = (bus.AluOp == c_OP_DIV) || (bus.AluOp == c_OP_REM);
    assign w_isrem = (bus.AluOp == c_OP_REM) || (bus.AluOp == c_OP_REMU);
    assign w_isdiv = (bus.AluOp >= c_OP_DIV) && (bus.AluOp <= c_OP_REMU);
    assign w_div0  = (w_b == 32'd0);
    assign w_ovf   = w_sgn && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_start = w_isdiv && !w_div0 && !w_ovf;
    assign w_mag_a = (w_sgn && w_a[31]) ? (32'd0 - w_a) : w_a;
    assign w_mag_b = (w_sgn && w_b[31]) ? (32'd0 - w_b) : w_b;
    assign w_fast  = w_div0 ? (w_isrem ? w_a : 32'hFFFF_FFFF)
                            : (w_isrem ? 32'd0 : 32'h8000_0000);

    // One 64x64 product covers all four multiplies; operand extension picks signedness.
    assign w_msgn_a = (bus.AluOp == c_OP_MULH) || (bus.AluOp == c_OP_MULHSU);
    assign w_msgn_b = (bus.AluOp == c_OP_MULH);
    assign w_xa     = {{32{w_msgn_a & w_a[31]}}, w_a};
    assign w_xb     = {{32{w_msgn_b & w_b[31]}}, w_b};
    assign w_prod   = w_xa * w_xb;

    assign w_trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    assign w_quot   = qneg_q ? (32'd0 - quo_q) : quo_q;
    assign w_remd   = rneg_q ? (32'd0 - rem_q) : rem_q;
    assign w_divres = (state_q == S_DONE) ? (w_isrem ? w_remd : w_quot) : w_fast;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        w_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = w_mag_a;
                    dvs_d   = w_mag_b;
                    qneg_d  = w_sgn & (w_a[31] ^ w_b[31]);
                    rneg_d  = w_sgn & w_a[31];
                    w_stall = 1'b1;
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                // quo_q shifts the dividend out at the top and collects quotient bits at the bottom
                if (!w_trial[32]) begin
                    rem_d = w_trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_alu = w_a + w_b;
        case (bus.AluOp)
            c_OP_ADD:   w_alu = w_a + w_b;
            c_OP_SUB:   w_alu = w_a - w_b;
            c_OP_SLL:   w_alu = w_a << w_b[4:0];
            c_OP_SLT:   w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            c_OP_SLTU:  w_alu = {31'd0, w_a < w_b};
            c_OP_XOR:   w_alu = w_a ^ w_b;
            c_OP_SRL:   w_alu = w_a >> w_b[4:0];
            c_OP_SRA:   w_alu = $signed(w_a) >>> w_b[4:0];
            c_OP_OR:    w_alu = w_a | w_b;
            c_OP_AND:   w_alu = w_a & w_b;
            c_OP_PASSB: w_alu = w_b;
`ifdef M_EXT_EN
            c_OP_MUL:                           w_alu = w_prod[31:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_alu = w_prod[63:32];
            c_OP_DIV, c_OP_DIVU, c_OP_REM, c_OP_REMU: w_alu = w_divres;
`else
            c_OP_MUL, c_OP_MULH, c_OP_MULHSU, c_OP_MULHU,
            c_OP_DIV, c_OP_DIVU, c_OP_REM, c_OP_REMU: w_alu = 32'd0;
`endif
            default: w_alu = w_a + w_b;
        endcase
    end

    always_comb begin
        case (bus.BranchOp)
            3'd0:    w_take = (bus.rs1_data == bus.rs2_data);
            3'd1:    w_take = (bus.rs1_data != bus.rs2_data);
            3'd4:    w_take = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'd5:    w_take = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'd6:    w_take = (bus.rs1_data <  bus.rs2_data);
            3'd7:    w_take = (bus.rs1_data >= bus.rs2_data);
            default: w_take = 1'b0;
        endcase
    end

    assign w_pcsrc  = bus.Jump | (bus.Branch & w_take);
    assign w_result = bus.Jump ? (bus.pc + 32'd4) : w_alu;
    assign w_bubble = bus.flush | w_stall;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            res_q   <= 32'd0;
            store_q <= 32'd0;
            tgt_q   <= 32'd0;
            rd_q    <= 5'd0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            pcs_q   <= 1'b0;
        end else begin
            res_q   <= w_result;
            store_q <= bus.rs2_data;
            tgt_q   <= w_target;
            rd_q    <= bus.RegDest;
            mr_q    <= bus.MemRead;
            mw_q    <= bus.MemWrite;
            m2r_q   <= bus.MemToReg;
            rw_q    <= bus.RegWrite;
            pcs_q   <= w_pcsrc;
        end
    end

    assign bus.out_AluResult    = res_q;
    assign bus.out_StoreData    = store_q;
    assign bus.out_BranchTarget = tgt_q;
    assign bus.out_RegDest      = rd_q;
    assign bus.out_MemRead      = mr_q;
    assign bus.out_MemWrite     = mw_q;
    assign bus.out_MemToReg     = m2r_q;
    assign bus.out_RegWrite     = rw_q;
    assign bus.out_PCSrc        = pcs_q;
    assign bus.stall_pipeline   = w_stall;
endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed and random stimulus for execute_stage against a
//            behavioural reference (honours M_EXT_EN like the design).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
`ifdef M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    execute_stage_if bus ();

    execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    // Cycles since a multi-cycle divide was accepted; -1 when none is in flight.
    int since = -1;
    int nx_since;
    logic m_stall = 1'b0;
    logic [31:0] nx_res, nx_st, nx_tg, ex_res, ex_st, ex_tg;
    logic [4:0]  nx_rd, ex_rd;
    logic nx_mr, nx_mw, nx_m2r, nx_rw, nx_pcs, nx_bub;
    logic ex_mr = 0, ex_mw = 0, ex_m2r = 0, ex_rw = 0, ex_pcs = 0, ex_bub = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        bit sgn = (op == 5'd15) || (op == 5'd17);
        bit rem = (op == 5'd17) || (op == 5'd18);
        int sa = a;
        int sb = b;
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) begin
            if (rem) return sa % sb;
            return sa / sb;
        end
        if (rem) return a % b;
        return a / b;
    endfunction

    function automatic logic [31:0] alu_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        int sa = a;
        int sb = b;
        int sh = b % 32;
        longint unsigned ua = a, ub = b;
        longint la = sa, lb = sb;
        logic [63:0] p;
        case (op)
            5'd1:  return a - b;
            5'd2:  return a << sh;
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> sh;
            5'd7:  return sa >>> sh;
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: begin p = ua * ub; return M_EN ? p[31:0] : 32'd0; end
            5'd12: begin p = la * lb; return M_EN ? p[63:32] : 32'd0; end
            5'd13: begin p = la * longint'(ub); return M_EN ? p[63:32] : 32'd0; end
            5'd14: begin p = ua * ub; return M_EN ? p[63:32] : 32'd0; end
            5'd15, 5'd16, 5'd17, 5'd18: return M_EN ? div_model(op, a, b) : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic bit branch_taken(logic [2:0] bop, logic [31:0] x, logic [31:0] y);
        int sx = x;
        int sy = y;
        case (bop)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return sx < sy;
            3'd5: return sx >= sy;
            3'd6: return x < y;
            3'd7: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_eval();
        logic [31:0] a, b;
        logic [4:0] op;
        bit sgn, slow;
        a    = bus.rs1_data;
        b    = bus.AluSrc ? bus.imm : bus.rs2_data;
        op   = bus.AluOp;
        sgn  = (op == 5'd15) || (op == 5'd17);
        slow = M_EN && (op >= 5'd15) && (op <= 5'd18) && (b != 0)
               && !(sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        m_stall = !bus.flush && ((since < 0 && slow) || (since >= 1 && since <= 32));
        {nx_res, nx_st, nx_tg, nx_rd} = '0;
        {nx_mr, nx_mw, nx_m2r, nx_rw, nx_pcs, nx_bub} = '0;
        nx_since = -1;
        if (rst) begin
            nx_bub = 1'b0;
        end else if (bus.flush || m_stall) begin
            nx_bub = 1'b1;
            if (!bus.flush) nx_since = (since < 0) ? 1 : since + 1;
        end else begin
            nx_res = (since == 33) ? div_model(op, a, b) : alu_model(op, a, b);
            if (bus.Jump) nx_res = bus.pc + 32'd4;
            nx_pcs = bus.Jump || (bus.Branch && branch_taken(bus.BranchOp, bus.rs1_data, bus.rs2_data));
            nx_tg  = (bus.Jump && bus.Jalr) ? ((bus.rs1_data + bus.imm) & 32'hFFFF_FFFE)
                                            : (bus.pc + bus.imm);
            nx_st  = bus.rs2_data;
            nx_rd  = bus.RegDest;
            nx_mr  = bus.MemRead;
            nx_mw  = bus.MemWrite;
            nx_m2r = bus.MemToReg;
            nx_rw  = bus.RegWrite;
        end
    endtask

    task automatic drive_cycle();
        model_eval();
        @(posedge clk);
        since  = nx_since;
        ex_res = nx_res; ex_st = nx_st; ex_tg = nx_tg; ex_rd = nx_rd;
        ex_mr = nx_mr; ex_mw = nx_mw; ex_m2r = nx_m2r; ex_rw = nx_rw; ex_pcs = nx_pcs; ex_bub = nx_bub;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", 32'(bus.stall_pipeline), 32'(m_stall));
            chk("RegWrite", 32'(bus.out_RegWrite), 32'(ex_rw));
            chk("MemRead", 32'(bus.out_MemRead), 32'(ex_mr));
            chk("MemWrite", 32'(bus.out_MemWrite), 32'(ex_mw));
            chk("PCSrc", 32'(bus.out_PCSrc), 32'(ex_pcs));
            if (!ex_bub) begin
                chk("AluResult", bus.out_AluResult, ex_res);
                chk("StoreData", bus.out_StoreData, ex_st);
                chk("BranchTarget", bus.out_BranchTarget, ex_tg);
                chk("RegDest", 32'(bus.out_RegDest), 32'(ex_rd));
                chk("MemToReg", 32'(bus.out_MemToReg), 32'(ex_m2r));
            end
        end
    end

    task automatic clear_inputs();
        bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0;
        bus.AluOp = 0; bus.AluSrc = 0; bus.Branch = 0; bus.Jump = 0; bus.Jalr = 0;
        bus.BranchOp = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemToReg = 0;
        bus.RegWrite = 0; bus.RegDest = 0; bus.flush = 0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            4: return 32'(0 - $urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_inputs();
        bus.pc       = $urandom & 32'hFFFF_FFFC;
        bus.rs1_data = rnd_val();
        bus.rs2_data = rnd_val();
        bus.imm      = rnd_val();
        if ($urandom_range(0, 99) < 12) bus.AluOp = 5'(15 + $urandom_range(0, 3));
        else                            bus.AluOp = 5'($urandom_range(0, 31));
        bus.AluSrc   = 1'($urandom_range(0, 1));
        bus.Branch   = ($urandom_range(0, 3) == 0);
        bus.Jump     = ($urandom_range(0, 7) == 0);
        bus.Jalr     = 1'($urandom_range(0, 1));
        bus.BranchOp = 3'($urandom_range(0, 7));
        bus.MemRead  = 1'($urandom_range(0, 1));
        bus.MemWrite = 1'($urandom_range(0, 1));
        bus.MemToReg = 1'($urandom_range(0, 1));
        bus.RegWrite = 1'($urandom_range(0, 1));
        bus.RegDest  = 5'($urandom_range(0, 31));
        bus.flush    = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        int n;
        clear_inputs();
        rst = 1'b1;
        drive_cycle();
        chk_on = 1'b1;
        drive_cycle();
        rst = 1'b0;
        chk("rst_AluResult", bus.out_AluResult, 32'd0);
        chk("rst_RegWrite", 32'(bus.out_RegWrite), 32'd0);
        chk("rst_stall", 32'(bus.stall_pipeline), 32'd0);

        // ADD wraps modulo 2^32
        clear_inputs();
        bus.rs1_data = 32'hFFFF_FFFF; bus.rs2_data = 32'd1; bus.RegDest = 5'd5; bus.RegWrite = 1;
        drive_cycle();
        chk("add_result", bus.out_AluResult, 32'd0);
        chk("add_rd", 32'(bus.out_RegDest), 32'd5);
        chk("add_stall", 32'(bus.stall_pipeline), 32'd0);

        clear_inputs();
        bus.Branch = 1; bus.BranchOp = 3'd4; bus.rs1_data = 32'hFFFF_FFFE; bus.rs2_data = 32'd1;
        bus.pc = 32'h100; bus.imm = 32'h20;
        drive_cycle();
        chk("blt_pcsrc", 32'(bus.out_PCSrc), 32'd1);
        chk("blt_target", bus.out_BranchTarget, 32'h120);
        bus.BranchOp = 3'd6;
        drive_cycle();
        chk("bltu_pcsrc", 32'(bus.out_PCSrc), 32'd0);

        clear_inputs();
        bus.Jump = 1; bus.pc = 32'h200; bus.imm = 32'h40; bus.rs1_data = 32'h1001;
        drive_cycle();
        chk("jal_link", bus.out_AluResult, 32'h204);
        chk("jal_target", bus.out_BranchTarget, 32'h240);
        chk("jal_pcsrc", 32'(bus.out_PCSrc), 32'd1);
        bus.Jalr = 1; bus.imm = 32'h10;
        drive_cycle();
        chk("jalr_target", bus.out_BranchTarget, 32'h1010);

        clear_inputs();
        bus.rs1_data = 32'd9; bus.RegWrite = 1; bus.MemWrite = 1; bus.flush = 1;
        drive_cycle();
        chk("flush_regwrite", 32'(bus.out_RegWrite), 32'd0);
        chk("flush_memwrite", 32'(bus.out_MemWrite), 32'd0);

        clear_inputs();
        bus.AluOp = 5'd11; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4; bus.RegWrite = 1; bus.RegDest = 5'd7;
        #1;
        chk("mul_stall", 32'(bus.stall_pipeline), 32'd0);
        drive_cycle();
`ifdef M_EXT_EN
        chk("mul_result", bus.out_AluResult, 32'd12);
        bus.AluOp = 5'd14; bus.rs1_data = 32'hFFFF_FFFF; bus.rs2_data = 32'hFFFF_FFFF;
        drive_cycle();
        chk("mulhu_result", bus.out_AluResult, 32'hFFFF_FFFE);

        clear_inputs();
        bus.AluOp = 5'd15; bus.rs1_data = 32'hFFFF_FFF9; bus.rs2_data = 32'd2; bus.RegWrite = 1;
        n = 0;
        for (int i = 0; i < 34; i++) begin
            #1;
            if (bus.stall_pipeline) n++;
            drive_cycle();
        end
        chk("div_stall_cycles", n, 33);
        chk("div_result", bus.out_AluResult, 32'hFFFF_FFFD);
        chk("div_regwrite", 32'(bus.out_RegWrite), 32'd1);
        bus.AluOp = 5'd17;
        for (int i = 0; i < 34; i++) drive_cycle();
        chk("rem_result", bus.out_AluResult, 32'hFFFF_FFFF);

        clear_inputs();
        bus.AluOp = 5'd16; bus.rs1_data = 32'd5; bus.rs2_data = 32'd0;
        #1;
        chk("divu0_stall", 32'(bus.stall_pipeline), 32'd0);
        drive_cycle();
        chk("divu0_result", bus.out_AluResult, 32'hFFFF_FFFF);
        bus.AluOp = 5'd15; bus.rs1_data = 32'h8000_0000; bus.rs2_data = 32'hFFFF_FFFF;
        #1;
        chk("ovf_stall", 32'(bus.stall_pipeline), 32'd0);
        drive_cycle();
        chk("ovf_result", bus.out_AluResult, 32'h8000_0000);

        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            bus.AluOp = 5'd15; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.RegWrite = 1;
            for (int i = 0; i < 11; i++) drive_cycle();
            if (k == 0) bus.flush = 1; else rst = 1'b1;
            drive_cycle();
            rst = 1'b0;
            clear_inputs();
            bus.rs1_data = 32'd1; bus.rs2_data = 32'd2; bus.RegWrite = 1;
            #1;
            chk("abort_stall", 32'(bus.stall_pipeline), 32'd0);
            chk("abort_bubble", 32'(bus.out_RegWrite), 32'd0);
            drive_cycle();
            chk("abort_add", bus.out_AluResult, 32'd3);
            chk("abort_add_rw", 32'(bus.out_RegWrite), 32'd1);
        end
`else
        chk("mul_result", bus.out_AluResult, 32'd0);
        chk("mul_rw_pass", 32'(bus.out_RegWrite), 32'd1);
        chk("mul_rd_pass", 32'(bus.out_RegDest), 32'd7);
        bus.AluOp = 5'd15; bus.rs1_data = 32'hFFFF_FFF9; bus.rs2_data = 32'd2;
        #1;
        chk("div_stall", 32'(bus.stall_pipeline), 32'd0);
        drive_cycle();
        chk("div_result", bus.out_AluResult, 32'd0);
`endif

        clear_inputs();
        for (int i = 0; i < 1500; i++) begin
            if (since >= 1) begin
                bus.flush = ($urandom_range(0, 29) == 0);
            end else begin
                random_inputs();
            end
            rst = ($urandom_range(0, 149) == 0);
            drive_cycle();
        end
        rst = 1'b0;
        clear_inputs();
        drive_cycle();
        drive_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
